// File: rtl/config_loader.sv
// config_loader: streams a byte-wide bitstream into a serial configuration chain.
//
// A start request clears the chain for one cycle (CLEAR), then bytes are taken
// on a valid/ready handshake and shifted out MSB-first, one bit per clock,
// until CHAIN_LENGTH bits have been delivered. Any bits left over in the final
// byte are dropped. The first bit shifted ends up at chain position
// CHAIN_LENGTH-1.
//
// Optional feature: define CONFIG_LOADER_CRC_EN to get a CRC-8 (poly 0x07,
// init 0x00, MSB-first, no final XOR) over the shifted bits. Without it, crc
// is tied to 0x00.
//
// Ports:
//   clock         - single clock; the chain shifts on its rising edge
//   nreset        - asynchronous active-low reset
//   start         - single-cycle load request (honoured in IDLE/DONE only)
//   data_in       - bitstream byte
//   data_valid    - data_in holds a valid byte
//   data_ready    - loader accepts data_in this cycle
//   config_in     - serial bit to the chain head (0 when not shifting)
//   config_enable - chain shift enable
//   config_nreset - active-low chain clear (low in CLEAR and during reset)
//   busy          - high in CLEAR and LOAD
//   done          - high in DONE
//   crc           - bitstream checksum (0x00 unless CONFIG_LOADER_CRC_EN)
module config_loader #(
  parameter int CHAIN_LENGTH = 36
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       config_in,
  output logic       config_enable,
  output logic       config_nreset,
  output logic       busy,
  output logic       done,
  output logic [7:0] crc
);

  localparam int CW = $clog2(CHAIN_LENGTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] bit_cnt;   // chain bits still to deliver
  logic [7:0]    hold;      // holding register, MSB is the next bit out
  logic [3:0]    hold_cnt;  // unshifted bits left in hold
  logic          shift_en;
  logic          accept;

  assign shift_en = (state == LOAD) && (hold_cnt != 4'd0) && (bit_cnt != '0);

  // Refill while the last bit of the current byte is going out so that
  // back-to-back bytes shift with no bubble, but never fetch a byte whose
  // bits would all be discarded.
  assign data_ready = (state == LOAD) &&
                      (((hold_cnt == 4'd0) && (bit_cnt != '0)) ||
                       ((hold_cnt == 4'd1) && (bit_cnt > CW'(1))));

  assign accept        = data_ready && data_valid;
  assign config_enable = shift_en;
  assign config_in     = shift_en && hold[7];
  assign config_nreset = nreset && (state != CLEAR);
  assign busy          = (state == CLEAR) || (state == LOAD);
  assign done          = (state == DONE);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      hold     <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) state <= CLEAR;
        end
        CLEAR: begin
          state    <= LOAD;
          bit_cnt  <= CW'(CHAIN_LENGTH);
          hold     <= '0;
          hold_cnt <= '0;
        end
        LOAD: begin
          if (shift_en) begin
            bit_cnt  <= bit_cnt - CW'(1);
            hold     <= {hold[6:0], 1'b0};
            hold_cnt <= hold_cnt - 4'd1;
            if (bit_cnt == CW'(1)) begin
              state    <= DONE;
              hold_cnt <= '0;
            end
          end
          // accept never coincides with the final bit (data_ready needs
          // bit_cnt > hold_cnt), so a refill cannot be lost to DONE.
          if (accept) begin
            hold     <= data_in;
            hold_cnt <= 4'd8;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONFIG_LOADER_CRC_EN
  logic [7:0] crc_q;
  logic       crc_fb;

  assign crc_fb = crc_q[7] ^ hold[7];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      crc_q <= '0;
    end else if (state == CLEAR) begin
      crc_q <= '0;
    end else if (shift_en) begin
      crc_q <= {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    end
  end

  assign crc = crc_q;
`else
  assign crc = '0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Testbench for config_loader: one 36-bit chain instance driven by directed and
// randomized loads, plus 1-bit and 8-bit chain instances for the boundary and
// checksum cases. Expected chain contents are derived from the byte stream
// (the first CHAIN_LENGTH bits, first bit at the top position); the expected
// checksum follows the CRC-8 definition bit by bit.
module tb_config_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset;

  // 36-bit chain instance
  logic       start_a, valid_a;
  logic [7:0] din_a;
  logic       ready_a, cin_a, cen_a, cnrst_a, busy_a, done_a;
  logic [7:0] crc_a;

  config_loader #(.CHAIN_LENGTH(36)) dut_a (
    .clock(clk), .nreset(nreset), .start(start_a), .data_in(din_a),
    .data_valid(valid_a), .data_ready(ready_a), .config_in(cin_a),
    .config_enable(cen_a), .config_nreset(cnrst_a), .busy(busy_a),
    .done(done_a), .crc(crc_a)
  );

  // small instances: index 0 -> 1-bit chain, index 1 -> 8-bit chain
  logic [1:0] start_s, valid_s, ready_s, cin_s, cen_s, cnrst_s, busy_s, done_s;
  logic [7:0] din_s [2];
  logic [7:0] crc_s [2];

  for (genvar g = 0; g < 2; g++) begin : g_small
    config_loader #(.CHAIN_LENGTH(g == 0 ? 1 : 8)) u_dut (
      .clock(clk), .nreset(nreset), .start(start_s[g]), .data_in(din_s[g]),
      .data_valid(valid_s[g]), .data_ready(ready_s[g]), .config_in(cin_s[g]),
      .config_enable(cen_s[g]), .config_nreset(cnrst_s[g]), .busy(busy_s[g]),
      .done(done_s[g]), .crc(crc_s[g])
    );
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // CRC-8 poly 0x07 over the n low bits of 'bits', most significant first.
  function automatic logic [7:0] crc_expect(input logic [63:0] bits, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[7] ^ bits[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
`ifdef CONFIG_LOADER_CRC_EN
    return c;
`else
    return 8'h00;
`endif
  endfunction

  // One load on the 36-bit instance. Called and returns at a negedge.
  //   gap_after : hold data_valid low for gap_len ready cycles once this many
  //               bytes have been accepted (out of range -> no gap)
  //   poke_bit  : pulse start when this many bits have shifted (-1: never)
  //   reset_bit : assert nreset when this many bits have shifted (-1: never)
  task automatic run_a(input logic [7:0] bytes [$], input int gap_after,
                       input int gap_len, input int poke_bit, input int reset_bit,
                       input string tag);
    int          idx, gap_left, en, first, last, exp_stall;
    bit          poked;
    logic [35:0] chain;
    logic [63:0] cat;
    logic [35:0] exp_chain;
    idx = 0; gap_left = gap_len; en = 0; first = -1; last = -1;
    poked = 1'b0; chain = '0;

    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check({tag, "_clear"}, {busy_a, cnrst_a, ready_a, cen_a, done_a}, 5'b10000);

    for (int cyc = 0; cyc < 400 && !done_a; cyc++) begin
      @(negedge clk);
      if (reset_bit >= 0 && en == reset_bit) begin
        nreset = 1'b0;
        #1;
        check({tag, "_rst_outs"},
              {ready_a, cen_a, cin_a, cnrst_a, busy_a, done_a, crc_a}, '0);
        @(negedge clk);
        nreset  = 1'b1;
        valid_a = 1'b0;
        #1;
        check({tag, "_rst_idle"}, {busy_a, done_a, cnrst_a, ready_a}, 4'b0010);
        return;
      end
      start_a = 1'b0;
      if (poke_bit >= 0 && en == poke_bit && !poked) begin
        start_a = 1'b1;
        poked   = 1'b1;
      end
      if (cen_a) begin
        en++;
        chain = {chain[34:0], cin_a};
        if (first < 0) first = cyc;
        last = cyc;
      end else begin
        check({tag, "_cin_idle"}, cin_a, 1'b0);
      end
      valid_a = 1'b0;
      if (idx < bytes.size()) begin
        if (idx == gap_after && ready_a && gap_left > 0) begin
          gap_left--;
        end else begin
          valid_a = 1'b1;
          din_a   = bytes[idx];
          if (ready_a) idx++;
        end
      end
    end
    start_a = 1'b0;
    valid_a = 1'b0;

    cat = '0;
    for (int i = 0; i < 5; i++) cat = (cat << 8) | 64'(bytes[i]);
    exp_chain = 36'(cat >> 4);
    exp_stall = (gap_after >= 1 && gap_after <= 4) ? gap_len : 0;

    check({tag, "_done"}, done_a, 1'b1);
    check({tag, "_enables"}, en, 36);
    check({tag, "_stall"}, (first < 0) ? -1 : (last - first + 1 - en), exp_stall);
    check({tag, "_chain"}, chain, exp_chain);
    check({tag, "_idle_outs"}, {busy_a, cnrst_a, ready_a, cen_a, cin_a}, 5'b01000);
    check({tag, "_crc"}, crc_a, crc_expect(64'(exp_chain), 36));
    @(negedge clk);
    check({tag, "_done_hold"}, {done_a, crc_a}, {1'b1, crc_expect(64'(exp_chain), 36)});
  endtask

  // One load of a single byte into a small instance.
  task automatic run_small(input int g, input int len, input logic [7:0] b, input string tag);
    int         en;
    logic [7:0] got;
    logic [7:0] exp_bits;
    bit         sent;
    en = 0; got = '0; sent = 1'b0;
    start_s[g] = 1'b1;
    @(negedge clk);
    start_s[g] = 1'b0;
    for (int c = 0; c < 50 && !done_s[g]; c++) begin
      @(negedge clk);
      if (cen_s[g]) begin
        en++;
        got = {got[6:0], cin_s[g]};
      end
      valid_s[g] = !sent;
      din_s[g]   = b;
      if (!sent && ready_s[g]) sent = 1'b1;
    end
    valid_s[g] = 1'b0;
    exp_bits = b >> (8 - len);
    check({tag, "_done"}, {done_s[g], busy_s[g]}, 2'b10);
    check({tag, "_enables"}, en, len);
    check({tag, "_bits"}, got, exp_bits);
    check({tag, "_crc"}, crc_s[g], crc_expect(64'(exp_bits), len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q [$];
    logic [7:0] exp_crc8;
    nreset = 1'b1;
    start_a = 1'b0; valid_a = 1'b0; din_a = '0;
    start_s = '0; valid_s = '0; din_s[0] = '0; din_s[1] = '0;

    #2 nreset = 1'b0;
    #1;
    check("reset_a", {ready_a, cen_a, cin_a, cnrst_a, busy_a, done_a, crc_a}, '0);
    check("reset_s", {ready_s, cen_s, cin_s, cnrst_s, busy_s, done_s, crc_s[0], crc_s[1]}, '0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("idle_a", {busy_a, done_a, cnrst_a, ready_a, cen_a}, 5'b00100);

    q = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'hF0};
    run_a(q, 99, 0, -1, -1, "stream");
    run_a(q, 2, 3, -1, -1, "gap3");
    run_a(q, 99, 0, 10, -1, "start_in_load");
    run_a(q, 99, 0, -1, 20, "reset_mid");
    run_a(q, 99, 0, -1, -1, "after_reset");

    for (int r = 0; r < 4; r++) begin
      q = {};
      for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
      run_a(q, int'($urandom_range(1, 4)), int'($urandom_range(0, 5)), -1, -1, "random");
    end

    run_small(0, 1, 8'h80, "len1");
    run_small(1, 8, 8'h01, "len8");
`ifdef CONFIG_LOADER_CRC_EN
    exp_crc8 = 8'h07;
`else
    exp_crc8 = 8'h00;
`endif
    check("len8_crc_const", crc_s[1], exp_crc8);
    run_small(1, 8, 8'($urandom), "len8_rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
